// File: rtl/game2048_pkg.sv
// -----------------------------------------------------------------------------
// game2048_pkg
//
// Shared definitions for the 2048 game core (move/merge, spawn and win
// detection blocks).
//
//   GRID_N  : board edge length in tiles
//   TILE_W  : tile width in bits; tiles hold the literal value (0 = empty)
//   MAX_WIN : win exponent; a tile wins when value >= 2**MAX_WIN
//   tile_t  : one tile
//   board_t : full board, indexed [row][col], row 0 = top, col 0 = left
// -----------------------------------------------------------------------------
package game2048_pkg;

    localparam int unsigned GRID_N  = 4;
    localparam int unsigned TILE_W  = 12;
    localparam int unsigned MAX_WIN = 11;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [GRID_N-1:0][GRID_N-1:0] board_t;

endpackage

// File: rtl/tile_win_cmp.sv
// -----------------------------------------------------------------------------
// tile_win_cmp
//
// Combinational per-tile win comparator. Flags a tile whose unsigned value is
// at or above 2**MAX_WIN. Any set bit at or above MAX_WIN counts, so
// non-power-of-two values (e.g. 12'hFFF) also win.
//
// Parameters:
//   TILE_W  : tile width in bits
//   MAX_WIN : win exponent (1 .. TILE_W-1)
//
// Ports:
//   tile : input  [TILE_W-1:0]  tile value
//   hit  : output               1 when tile >= 2**MAX_WIN
// -----------------------------------------------------------------------------
module tile_win_cmp #(
    parameter int unsigned TILE_W  = 12,
    parameter int unsigned MAX_WIN = 11
) (
    input  logic [TILE_W-1:0] tile,
    output logic              hit
);

    localparam logic [TILE_W-1:0] Threshold = TILE_W'(1) << MAX_WIN;

    // Full unsigned compare; equivalent to OR of bits [TILE_W-1:MAX_WIN].
    assign hit = (tile >= Threshold);

endmodule

// File: rtl/check_win.sv
// -----------------------------------------------------------------------------
// check_win
//
// Win detector for the 2048 game core. Watches the 4x4 board every clock and
// raises a registered flag when any tile reaches 2**MAX_WIN. Purely
// observational; the board is never modified. The flag is not sticky: it
// follows the board with exactly one clock of latency.
//
// Configuration macro:
//   CHECK_WIN_POS_EN : when defined, adds registered win_row/win_col outputs
//                      giving the first winning tile in row-major order.
//
// Parameters:
//   MAX_WIN : win exponent, legal range 1 .. TILE_W-1
//   TILE_W  : tile width in bits
//
// Ports:
//   clk      : input               system clock, rising edge
//   rst      : input               synchronous active-high reset
//   board_in : input  [TILE_W-1:0] x [3:0][3:0] unpacked, [row][col]
//   win_row  : output [1:0]        (CHECK_WIN_POS_EN) row of first winner
//   win_col  : output [1:0]        (CHECK_WIN_POS_EN) col of first winner
//   result   : output              registered win flag
// -----------------------------------------------------------------------------
module check_win #(
    parameter int unsigned MAX_WIN = game2048_pkg::MAX_WIN,
    parameter int unsigned TILE_W  = game2048_pkg::TILE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TILE_W-1:0] board_in [3:0][3:0],
`ifdef CHECK_WIN_POS_EN
    output logic [1:0]        win_row,
    output logic [1:0]        win_col,
`endif
    output logic              result
);

    import game2048_pkg::*;

    // Reject illegal configurations at elaboration time.
    if (MAX_WIN < 1 || MAX_WIN >= TILE_W) begin : g_param_check
        $error("check_win: MAX_WIN must lie in 1 .. TILE_W-1");
    end

    // -------------------------------------------------------------------------
    // Per-tile comparators
    // -------------------------------------------------------------------------
    logic [GRID_N-1:0][GRID_N-1:0] win_hit;
    logic                          win_any;

    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            tile_win_cmp #(
                .TILE_W  (TILE_W),
                .MAX_WIN (MAX_WIN)
            ) u_cmp (
                .tile (board_in[r][c]),
                .hit  (win_hit[r][c])
            );
        end
    end

    assign win_any = |win_hit;

    // -------------------------------------------------------------------------
    // Result register
    // -------------------------------------------------------------------------
    logic result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 1'b0;
        end else begin
            result_q <= win_any;
        end
    end

    assign result = result_q;

`ifdef CHECK_WIN_POS_EN
    // -------------------------------------------------------------------------
    // Row-major priority encoder: lowest row wins, then lowest column.
    // Position is 0/0 whenever no tile wins, so it is 0 whenever result is 0.
    // -------------------------------------------------------------------------
    logic [1:0] win_row_d, win_row_q;
    logic [1:0] win_col_d, win_col_q;
    logic       found;

    always_comb begin
        win_row_d = 2'd0;
        win_col_d = 2'd0;
        found     = 1'b0;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                if (!found && win_hit[r][c]) begin
                    found     = 1'b1;
                    win_row_d = 2'(r);
                    win_col_d = 2'(c);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_row_q <= 2'd0;
            win_col_q <= 2'd0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

endmodule

// File: tb/tb_check_win.sv
// -----------------------------------------------------------------------------
// tb_check_win
//
// Directed self-checking bench for check_win. Works with or without
// CHECK_WIN_POS_EN; position checks are only compiled in when it is defined.
// -----------------------------------------------------------------------------
module tb_check_win;

    logic        clk;
    logic        rst;
    logic [11:0] board [3:0][3:0];
    logic        result;
`ifdef CHECK_WIN_POS_EN
    logic [1:0]  win_row;
    logic [1:0]  win_col;
`endif

    int checks = 0;
    int errors = 0;

    check_win #(
        .MAX_WIN (11),
        .TILE_W  (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .board_in (board),
`ifdef CHECK_WIN_POS_EN
        .win_row  (win_row),
        .win_col  (win_col),
`endif
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_board();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                board[r][c] = 12'd0;
    endtask

    task automatic fill_board(input logic [11:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                board[r][c] = v;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks result and, when built in, the winning position.
    task automatic check_out(input string tag, input logic exp_res,
                             input logic [1:0] exp_row, input logic [1:0] exp_col);
        check({tag, ".result"}, {1'b0, result}, {1'b0, exp_res});
`ifdef CHECK_WIN_POS_EN
        check({tag, ".win_row"}, win_row, exp_row);
        check({tag, ".win_col"}, win_col, exp_col);
`else
        if (exp_row != exp_col) begin end
`endif
    endtask

    initial begin
        rst = 1'b1;
        clear_board();
        tick();
        tick();
        check_out("reset", 1'b0, 2'd0, 2'd0);

        rst = 1'b0;
        tick();
        tick();
        check_out("empty", 1'b0, 2'd0, 2'd0);

        // Single 2048 at [1][1]; result must not move before the edge.
        board[1][1] = 12'd2048;
        #1;
        check_out("latency_pre_edge", 1'b0, 2'd0, 2'd0);
        tick();
        check_out("win_1_1", 1'b1, 2'd1, 2'd1);

        // Non-sticky de-assertion.
        board[1][1] = 12'd0;
        board[2][1] = 12'd64;
        tick();
        check_out("deassert", 1'b0, 2'd0, 2'd0);

        // Garbage above threshold still wins.
        clear_board();
        board[0][3] = 12'hFFF;
        tick();
        check_out("garbage_fff", 1'b1, 2'd0, 2'd3);

        // Every tile at 1024: no win.
        fill_board(12'd1024);
        tick();
        check_out("all_1024", 1'b0, 2'd0, 2'd0);

        // One below the threshold everywhere: no win.
        fill_board(12'd2047);
        tick();
        check_out("all_2047", 1'b0, 2'd0, 2'd0);

        // Non-power-of-two just above threshold, bottom-left.
        clear_board();
        board[3][0] = 12'h801;
        tick();
        check_out("win_801_3_0", 1'b1, 2'd3, 2'd0);

        // Two winners: row-major first is [0][2].
        clear_board();
        board[3][3] = 12'd2048;
        board[0][2] = 12'd2048;
        tick();
        check_out("two_winners", 1'b1, 2'd0, 2'd2);

        // Same row, two winners: lower column first.
        clear_board();
        board[2][3] = 12'd4095;
        board[2][1] = 12'd2048;
        tick();
        check_out("same_row", 1'b1, 2'd2, 2'd1);

        // Reset priority with a winning board present.
        clear_board();
        board[3][3] = 12'd2048;
        rst = 1'b1;
        tick();
        check_out("rst_cyc1", 1'b0, 2'd0, 2'd0);
        tick();
        check_out("rst_cyc2", 1'b0, 2'd0, 2'd0);
        tick();
        check_out("rst_cyc3", 1'b0, 2'd0, 2'd0);
        rst = 1'b0;
        #1;
        check_out("rst_release_pre_edge", 1'b0, 2'd0, 2'd0);
        tick();
        check_out("rst_release", 1'b1, 2'd3, 2'd3);

        // Clearing the board drops result again.
        clear_board();
        tick();
        check_out("final_clear", 1'b0, 2'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
